// File: rtl/add_np_if.sv
// Operand/result handshake bundle for the segmented pipelined adder.
// slave = adder side, master = producer/consumer side.
interface add_np_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, x, y, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, x, y, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/add_np.sv
// Segmented pipelined adder/subtractor. The carry ripples one SEG_WIDTH
// segment per clock. Each stage register carries the full operand words
// forward (skew) and the partially built sum (deskew); bits no later stage
// reads are dead and get trimmed. One global advance enable stalls everything.

// One segment of the ripple: SW-bit add with carry in/out.
module add_np_seg #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
endmodule

module add_np #(
    parameter int WIDTH     = 16,
    parameter int SEG_WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    add_np_if.slave  bus
);
    localparam int NUM_SEG = WIDTH / SEG_WIDTH;
    localparam int STAGES  = NUM_SEG - 1;
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_WIDTH{1'b1}});

    if ((WIDTH % SEG_WIDTH) != 0 || NUM_SEG < 1) begin : g_bad_seg
        $error("add_np: WIDTH must be a non-zero multiple of SEG_WIDTH");
    end
    if ($bits(bus.x) != WIDTH) begin : g_bad_if
        $error("add_np: interface WIDTH does not match adder WIDTH");
    end

    logic                                 adv;
    logic [WIDTH-1:0]                     b_in;
    logic [STAGES:0]                      vld_pipe;
    // stage inputs (a*, b*, cin, partial sum) and next values
    logic [NUM_SEG-1:0][WIDTH-1:0]        ax, by, sin, sd;
    logic [NUM_SEG-1:0]                   cin, seg_c;
    logic [NUM_SEG-1:0][SEG_WIDTH-1:0]    seg_s;
    // stage registers
    logic [NUM_SEG-1:0][WIDTH-1:0]        xq, yq, sq;
    logic [NUM_SEG-1:0]                   cq;
    logic                                 ovf_d, ovf_q;
    logic                                 unused_bits;

    // subtraction is x + ~y + 1; the +1 enters as stage-0 carry-in
    assign b_in = bus.sub ? ~bus.y : bus.y;

    for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign ax[k]  = bus.x;
            assign by[k]  = b_in;
            assign cin[k] = bus.sub;
            assign sin[k] = '0;
        end else begin : g_next
            assign ax[k]  = xq[k-1];
            assign by[k]  = yq[k-1];
            assign cin[k] = cq[k-1];
            assign sin[k] = sq[k-1];
        end

        add_np_seg #(.SW(SEG_WIDTH)) u_seg (
            .a  (ax[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .b  (by[k][k*SEG_WIDTH +: SEG_WIDTH]),
            .ci (cin[k]),
            .s  (seg_s[k]),
            .co (seg_c[k])
        );

        // drop this stage's segment into the partial sum travelling along
        assign sd[k] = (sin[k] & ~(SEG_MASK << (k*SEG_WIDTH)))
                     | (WIDTH'(seg_s[k]) << (k*SEG_WIDTH));
    end

    // signed overflow from operand MSBs that reached the last stage
    assign ovf_d = (ax[STAGES][WIDTH-1] == by[STAGES][WIDTH-1])
                && (sd[STAGES][WIDTH-1] != ax[STAGES][WIDTH-1]);

    assign adv           = !vld_pipe[STAGES] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.sum       = sq[STAGES];
    assign bus.cout      = cq[STAGES];
    assign bus.ovf       = ovf_q;

    // operand copies past the last stage and already-consumed segments are dead
    assign unused_bits = ^{xq, yq};

    // pipeline advance: all stages move together or all hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            xq       <= '0;
            yq       <= '0;
            sq       <= '0;
            cq       <= '0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            vld_pipe[0] <= bus.in_valid;
            for (int k = 1; k < NUM_SEG; k++) vld_pipe[k] <= vld_pipe[k-1];
            xq    <= ax;
            yq    <= by;
            sq    <= sd;
            cq    <= seg_c;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: doc/add_np.md
# add_np

Parametrised N-stage pipelined two-operand adder/subtractor with valid/ready flow control. It is the successor to the fixed two-segment 16-bit pipelined adder. The operand is split into NUM_SEG = WIDTH/SEG_WIDTH segments and the carry ripples one segment per clock through skew/deskew registers. The block sits in the datapath between an operand producer and a result consumer and adds per-operation add/sub mode, carry-out, signed overflow and backpressure.

## Interface
- WIDTH, 16, operand and result width in bits.
- SEG_WIDTH, 8, bits summed per pipeline stage.
  - WIDTH % SEG_WIDTH must be 0; a violation is an elaboration error.
  - NUM_SEG = WIDTH/SEG_WIDTH and must be ≥ 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set offered.
- in_ready  out  1  the block accepts the operands at this edge.
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B.
- sub  in  1  0: sum = x + y; 1: sum = x − y (computed as x + ~y + 1).
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB.
  - add: 1 = unsigned overflow.
  - sub: 1 = no borrow (x ≥ y unsigned).
- ovf  out  1  two's-complement signed overflow of the operation.

## Operation
- Transfer rules:
  - Input is accepted when in_valid && in_ready at a rising edge.
  - Output is consumed when out_valid && out_ready at a rising edge.
- Pipeline is NUM_SEG register stages with one global advance enable: adv = !out_valid || out_ready, and in_ready = adv.
  - When adv = 0 every stage, including valid bits and skew registers, holds.
  - No bubble collapsing: a bubble (in_valid=0 while adv=1) enters as valid=0 and travels with the data.
- Stage k (0..NUM_SEG−1) sums segment k of x and segment k of y (y inverted when sub=1) plus the carry registered by stage k−1.
  - For stage 0 the carry-in is sub.
  - Its SEG_WIDTH-bit result and carry are registered.
- Skew registers delay segment k of x, y (and the sub bit) by k stages.
- Deskew registers delay the result of segment k by NUM_SEG−1−k stages, so all segments of one operation reach the output together.
- cout is the registered carry of stage NUM_SEG−1.
- ovf = (a_msb == b_msb) && (sum_msb != a_msb).
  - a = x, and b = y for add or ~y for sub.
  - The operand MSBs are carried in the skew path to the last stage.
- sum, cout and ovf are registered outputs. They are meaningful only while out_valid = 1, and hold their value during a stall.
- NUM_SEG = 1 degenerates to a single registered full-width adder with latency 1.

## Timing
- Reset (rst_n = 0, asynchronous assert, synchronous release on the next clk edge after deassert):
  - out_valid=0, sum=0, cout=0, ovf=0, and every internal valid bit 0.
  - in_ready=1 combinationally once out_valid=0.
- Latency: an operation accepted at edge n, with no stall, shows out_valid=1 and the valid result right after edge n+NUM_SEG−1.
  - This equals NUM_SEG cycles from the cycle in_valid was presented.
- Throughput: one operation per clock while out_ready=1.
- Stall:
  - If out_valid=1 and out_ready=0, in_ready drops in the same cycle (combinational from out_valid and out_ready).
  - Inputs are not sampled until out_ready returns.
  - Nothing is lost or duplicated.
- Simultaneous events: out_ready=1 while out_valid=1 and a new in_valid=1 in the same cycle means both transfers happen at that edge.
- Reset mid-operation: all in-flight operations are discarded. No out_valid pulse for them ever appears after reset.
- Wrap-around: sum is truncated to WIDTH bits, and the carry is reported only on cout.

## Test plan
- WIDTH=16, SEG_WIDTH=8:
  - Input: x=00FF, y=0001, sub=0.
  - Expect: sum=0100, cout=0, ovf=0, out_valid exactly 2 cycles after presentation; this checks the inter-segment carry.
- Wrap and overflow flags (WIDTH=16):
  - x=FFFF + y=0001 → sum=0000, cout=1, ovf=0.
  - x=7FFF + y=0001 → sum=8000, cout=0, ovf=1.
- Subtract (WIDTH=16):
  - x=8000 − y=0001 → sum=7FFF, cout=1, ovf=1.
  - x=0003 − y=0005 → sum=FFFE, cout=0, ovf=0.
- Streaming: 20 back-to-back random ops with out_ready=1 → 20 results in order, one per clock, each equal to a scoreboard (x±y) mod 2^16.
- Backpressure:
  - Stream 6 ops and hold out_ready=0 for 4 cycles mid-stream.
  - Expect: in_ready=0 during the hold, outputs stable, and all 6 results in order with none dropped or duplicated.
- WIDTH=32, SEG_WIDTH=8: x=00FFFFFF + y=00000001 → 01000000 after a 4-cycle latency.
  - Assert rst_n=0 with 3 ops in flight → out_valid=0 immediately, and no stale result afterwards.
